// File: rtl/bayer_demosaic_pkg.sv
// Shared types for the bilinear Bayer demosaic engine: FSM states, colour
// codes, Bayer phase constants and the pixel colour decode.
package bayer_demosaic_pkg;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2
  } colour_t;

  localparam logic [1:0] PAT_RGGB = 2'b00;
  localparam logic [1:0] PAT_GRBG = 2'b01;
  localparam logic [1:0] PAT_GBRG = 2'b10;
  localparam logic [1:0] PAT_BGGR = 2'b11;

  // Phase {row^pr, col^pc}: 00 red, 11 blue, otherwise green.
  function automatic colour_t colour_of(input logic r0, input logic c0,
                                        input logic [1:0] pat);
    logic [1:0] ph;
    ph = {r0 ^ pat[1], c0 ^ pat[0]};
    case (ph)
      2'b00:   colour_of = COL_RED;
      2'b11:   colour_of = COL_BLUE;
      default: colour_of = COL_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/bayer_nbr_addr.sv
// Neighbour address generator: for fetch step k, returns the mirrored
// addresses read on the two interpolated planes of the centre pixel.
module bayer_nbr_addr
  import bayer_demosaic_pkg::*;
#(
  parameter int COLS_LOG2 = 7,
  parameter int ROWS_LOG2 = 7,
  localparam int AW = COLS_LOG2 + ROWS_LOG2
) (
  input  logic [ROWS_LOG2-1:0] row,
  input  logic [COLS_LOG2-1:0] col,
  input  logic [1:0]           k,
  input  colour_t              pclass,
  output logic [AW-1:0]        addr_p0,
  output logic [AW-1:0]        addr_p1
);

  localparam logic [ROWS_LOG2-1:0] RMAX = '1;
  localparam logic [COLS_LOG2-1:0] CMAX = '1;

  logic [ROWS_LOG2-1:0] rm, rp;
  logic [COLS_LOG2-1:0] cm, cp;

  // Mirror at the borders so the neighbour keeps the centre's colour parity.
  always_comb begin
    if (row == '0) rm = ROWS_LOG2'(1);
    else           rm = row - ROWS_LOG2'(1);
    if (row == RMAX) rp = RMAX - ROWS_LOG2'(1);
    else             rp = row + ROWS_LOG2'(1);
    if (col == '0) cm = COLS_LOG2'(1);
    else           cm = col - COLS_LOG2'(1);
    if (col == CMAX) cp = CMAX - COLS_LOG2'(1);
    else             cp = col + COLS_LOG2'(1);
  end

  // Green: p0 horizontal, p1 vertical. Red/blue: p0 cross, p1 diagonal.
  always_comb begin
    addr_p0 = '0;
    addr_p1 = '0;
    if (pclass == COL_GREEN) begin
      if (k[0] == 1'b0) begin
        addr_p0 = {row, cm};
        addr_p1 = {rm, col};
      end else begin
        addr_p0 = {row, cp};
        addr_p1 = {rp, col};
      end
    end else begin
      case (k)
        2'd0: begin addr_p0 = {rm, col}; addr_p1 = {rm, cm}; end
        2'd1: begin addr_p0 = {row, cm}; addr_p1 = {rm, cp}; end
        2'd2: begin addr_p0 = {row, cp}; addr_p1 = {rp, cm}; end
        2'd3: begin addr_p0 = {rp, col}; addr_p1 = {rp, cp}; end
        default: begin addr_p0 = '0; addr_p1 = '0; end
      endcase
    end
  end

endmodule

// File: rtl/bayer_demosaic_p.sv
// Bilinear Bayer demosaic: loads a raw frame into R/G/B planes, then fills in
// the missing colours per pixel. BAYER_DEMOSAIC_ROUND_EN enables round-half-up.
module bayer_demosaic_p
  import bayer_demosaic_pkg::*;
#(
  parameter int DW        = 8,
  parameter int COLS_LOG2 = 7,
  parameter int ROWS_LOG2 = 7,
  localparam int AW = COLS_LOG2 + ROWS_LOG2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_en,
  input  logic [DW-1:0] data_in,
  input  logic [1:0]    pattern,
  output logic          wr_r,
  output logic          wr_g,
  output logic          wr_b,
  output logic [AW-1:0] addr_r,
  output logic [AW-1:0] addr_g,
  output logic [AW-1:0] addr_b,
  output logic [DW-1:0] wdata_r,
  output logic [DW-1:0] wdata_g,
  output logic [DW-1:0] wdata_b,
  input  logic [DW-1:0] rdata_r,
  input  logic [DW-1:0] rdata_g,
  input  logic [DW-1:0] rdata_b,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_IDX = '1;

  state_t        state;
  logic [AW-1:0] index;
  logic [1:0]    k;
  logic [DW+1:0] acc0, acc1;
  logic [1:0]    pat_q;

  logic [1:0]    cur_pat;
  colour_t       cur_col, plane0, plane1;
  logic          is_green, red_row;
  logic [1:0]    last_k;
  logic [DW-1:0] rd0, rd1, res0, res1;
  logic [DW+1:0] rnd;
  logic [AW-1:0] nbr0, nbr1, a0, a1;
  logic          we;

  // The first sample of a frame uses the live pattern; it is latched with it.
  always_comb begin
    if (state == ST_LOAD && index == '0) cur_pat = pattern;
    else                                 cur_pat = pat_q;
    cur_col  = colour_of(index[COLS_LOG2], index[0], cur_pat);
    red_row  = ~(index[COLS_LOG2] ^ cur_pat[1]);
    is_green = (cur_col == COL_GREEN);
    if (is_green) last_k = 2'd1;
    else          last_k = 2'd3;
  end

  // Map the two neighbour streams onto the planes this pixel lacks.
  always_comb begin
    case (cur_col)
      COL_RED:  begin plane0 = COL_GREEN; plane1 = COL_BLUE; end
      COL_BLUE: begin plane0 = COL_GREEN; plane1 = COL_RED;  end
      default: begin
        if (red_row) begin plane0 = COL_RED;  plane1 = COL_BLUE; end
        else         begin plane0 = COL_BLUE; plane1 = COL_RED;  end
      end
    endcase
  end

  // Select returning read data for each accumulator.
  always_comb begin
    case (plane0)
      COL_RED:   rd0 = rdata_r;
      COL_BLUE:  rd0 = rdata_b;
      default:   rd0 = rdata_g;
    endcase
    case (plane1)
      COL_RED:   rd1 = rdata_r;
      COL_BLUE:  rd1 = rdata_b;
      default:   rd1 = rdata_g;
    endcase
  end

  // Average of 2 or 4 operands; the DW+2-bit sum cannot overflow.
  always_comb begin
`ifdef BAYER_DEMOSAIC_ROUND_EN
    if (is_green) rnd = (DW+2)'(1);
    else          rnd = (DW+2)'(2);
`else
    rnd = '0;
`endif
    if (is_green) begin
      res0 = DW'((acc0 + rnd) >> 1);
      res1 = DW'((acc1 + rnd) >> 1);
    end else begin
      res0 = DW'((acc0 + rnd) >> 2);
      res1 = DW'((acc1 + rnd) >> 2);
    end
  end

  bayer_nbr_addr #(
    .COLS_LOG2(COLS_LOG2),
    .ROWS_LOG2(ROWS_LOG2)
  ) u_nbr (
    .row    (index[AW-1:COLS_LOG2]),
    .col    (index[COLS_LOG2-1:0]),
    .k      (k),
    .pclass (cur_col),
    .addr_p0(nbr0),
    .addr_p1(nbr1)
  );

  // Main FSM with index counter, fetch step and accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOAD;
      index <= '0;
      k     <= 2'd0;
      acc0  <= '0;
      acc1  <= '0;
      pat_q <= PAT_RGGB;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_en) begin
            if (index == '0) pat_q <= pattern;
            if (index == LAST_IDX) begin
              state <= ST_FETCH;
              index <= '0;
              k     <= 2'd0;
            end else begin
              index <= index + AW'(1);
            end
          end
        end
        ST_FETCH: begin
          // Step 0 sees stale read data from the previous pixel.
          if (k == 2'd0) begin
            acc0 <= '0;
            acc1 <= '0;
          end else begin
            acc0 <= acc0 + {2'b00, rd0};
            acc1 <= acc1 + {2'b00, rd1};
          end
          if (k == last_k) state <= ST_DRAIN;
          else             k     <= k + 2'd1;
        end
        ST_DRAIN: begin
          acc0  <= acc0 + {2'b00, rd0};
          acc1  <= acc1 + {2'b00, rd1};
          k     <= 2'd0;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          k <= 2'd0;
          if (index == LAST_IDX) begin
            index <= '0;
            state <= ST_DONE;
          end else begin
            index <= index + AW'(1);
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          index <= '0;
          state <= ST_LOAD;
        end
        default: begin
          index <= '0;
          state <= ST_LOAD;
        end
      endcase
    end
  end

  assign busy = (state == ST_FETCH) || (state == ST_DRAIN) || (state == ST_WRITE);
  assign done = (state == ST_DONE);

  always_comb begin
    we = (state == ST_WRITE);
    if (we) begin
      a0 = index;
      a1 = index;
    end else begin
      a0 = nbr0;
      a1 = nbr1;
    end
  end

  // Plane port drive: raw writes in LOAD, neighbour reads in FETCH, results in WRITE.
  always_comb begin
    wr_r = 1'b0;  wr_g = 1'b0;  wr_b = 1'b0;
    addr_r = '0;  addr_g = '0;  addr_b = '0;
    wdata_r = '0; wdata_g = '0; wdata_b = '0;
    if (reset) begin
      wr_r = 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_en) begin
            case (cur_col)
              COL_RED:  begin wr_r = 1'b1; addr_r = index; wdata_r = data_in; end
              COL_BLUE: begin wr_b = 1'b1; addr_b = index; wdata_b = data_in; end
              default:  begin wr_g = 1'b1; addr_g = index; wdata_g = data_in; end
            endcase
          end else begin
            wr_r = 1'b0;
          end
        end
        ST_FETCH, ST_WRITE: begin
          case (plane0)
            COL_RED:  begin addr_r = a0; wr_r = we; wdata_r = we ? res0 : '0; end
            COL_BLUE: begin addr_b = a0; wr_b = we; wdata_b = we ? res0 : '0; end
            default:  begin addr_g = a0; wr_g = we; wdata_g = we ? res0 : '0; end
          endcase
          case (plane1)
            COL_RED:  begin addr_r = a1; wr_r = we; wdata_r = we ? res1 : '0; end
            COL_BLUE: begin addr_b = a1; wr_b = we; wdata_b = we ? res1 : '0; end
            default:  begin addr_g = a1; wr_g = we; wdata_g = we ? res1 : '0; end
          endcase
        end
        default: begin
          wr_r = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bayer_demosaic_p.sv
// Directed bench for bayer_demosaic_p on a 4x4, 8-bit frame with behavioural planes.
module tb_bayer_demosaic_p;

  localparam int DW = 8;
  localparam int NPIX = 16;
`ifdef BAYER_DEMOSAIC_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [1:0]    pattern = 2'b00;
  logic          wr_r, wr_g, wr_b, busy, done;
  logic [3:0]    addr_r, addr_g, addr_b;
  logic [DW-1:0] wdata_r, wdata_g, wdata_b;
  logic [DW-1:0] rdata_r, rdata_g, rdata_b;

  logic [DW-1:0] mem_r [NPIX];
  logic [DW-1:0] mem_g [NPIX];
  logic [DW-1:0] mem_b [NPIX];
  logic [DW-1:0] snap_r [NPIX];
  logic [DW-1:0] snap_g [NPIX];
  logic [DW-1:0] snap_b [NPIX];
  logic [DW-1:0] cur [NPIX];

  logic [DW-1:0] ramp_t [NPIX] = '{8'd10, 8'd40, 8'd30, 8'd50, 8'd80, 8'd90, 8'd70, 8'd20,
                                   8'd15, 8'd25, 8'd35, 8'd45, 8'd55, 8'd65, 8'd75, 8'd85};
  logic [DW-1:0] rnd_t  [NPIX] = '{8'd1, 8'd7, 8'd2, 8'd9, 8'd4, 8'd6, 8'd8, 8'd3,
                                   8'd11, 8'd13, 8'd12, 8'd5, 8'd14, 8'd10, 8'd16, 8'd17};

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int cyc;

  always #5 clk = ~clk;

  bayer_demosaic_p #(.DW(DW), .COLS_LOG2(2), .ROWS_LOG2(2)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .data_in(data_in), .pattern(pattern),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
    .addr_r(addr_r), .addr_g(addr_g), .addr_b(addr_b),
    .wdata_r(wdata_r), .wdata_g(wdata_g), .wdata_b(wdata_b),
    .rdata_r(rdata_r), .rdata_g(rdata_g), .rdata_b(rdata_b),
    .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (wr_r) mem_r[addr_r] <= wdata_r;
    if (wr_g) mem_g[addr_g] <= wdata_g;
    if (wr_b) mem_b[addr_b] <= wdata_b;
    rdata_r <= mem_r[addr_r];
    rdata_g <= mem_g[addr_g];
    rdata_b <= mem_b[addr_b];
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tcol(int r, int c, logic [1:0] pat);
    int a, b;
    a = (r + int'(pat[1])) % 2;
    b = (c + int'(pat[0])) % 2;
    if (a == 0 && b == 0) return 0;
    else if (a == 1 && b == 1) return 2;
    else return 1;
  endfunction

  function automatic int mir(int x);
    if (x < 0) return -x;
    else if (x > 3) return 6 - x;
    else return x;
  endfunction

  // Reference: average every same-colour pixel in the mirrored 3x3 window.
  function automatic int model(int r, int c, int col, logic [1:0] pat);
    int sum, n, rr, cc;
    if (tcol(r, c, pat) == col) return int'(cur[r*4+c]);
    sum = 0; n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) begin
          rr = mir(r + dr); cc = mir(c + dc);
          if (tcol(rr, cc, pat) == col) begin
            sum += int'(cur[rr*4+cc]); n++;
          end
        end
    if (RND) return (sum + n/2) / n;
    else     return sum / n;
  endfunction

  task automatic load_frame(input logic [1:0] pat, input bit gaps);
    int ec;
    for (int i = 0; i < NPIX; i++) begin
      if (gaps && (i % 3 == 1)) begin
        @(posedge clk); #1;
        in_en = 1'b0; data_in = 8'hA5; pattern = ~pat;
      end
      @(posedge clk); #1;
      in_en = 1'b1; data_in = cur[i]; pattern = pat;
      if (i == 0) begin
        #1;
        ec = tcol(0, 0, pat);
        chk("load0_wr_r", 32'(wr_r), 32'(ec == 0));
        chk("load0_wr_g", 32'(wr_g), 32'(ec == 1));
        chk("load0_wr_b", 32'(wr_b), 32'(ec == 2));
        chk("load0_wdata", 32'(ec == 0 ? wdata_r : (ec == 1 ? wdata_g : wdata_b)), 32'(cur[0]));
      end
    end
    @(posedge clk); #1;
    in_en = 1'b0;
  endtask

  task automatic wait_done();
    cyc = 1;
    chk("busy_fetch", 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_latency", cyc, 32'd81);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_model(input logic [1:0] pat, input string tag);
    for (int p = 0; p < NPIX; p++) begin
      chk($sformatf("%s_r%0d", tag, p), 32'(mem_r[p]), model(p/4, p%4, 0, pat));
      chk($sformatf("%s_g%0d", tag, p), 32'(mem_g[p]), model(p/4, p%4, 1, pat));
      chk($sformatf("%s_b%0d", tag, p), 32'(mem_b[p]), model(p/4, p%4, 2, pat));
    end
  endtask

  initial begin
    for (int p = 0; p < NPIX; p++) begin
      mem_r[p] = '0; mem_g[p] = '0; mem_b[p] = '0;
    end
    #1 reset = 1'b1;
    #1;
    chk("rst_wr", 32'({wr_r, wr_g, wr_b}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("post_rst_addr", 32'({addr_r, addr_g, addr_b}), 32'd0);
    chk("post_rst_wdata", 32'({wdata_r, wdata_g, wdata_b}), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Flat frame
    for (int p = 0; p < NPIX; p++) cur[p] = 8'd100;
    load_frame(2'b00, 1'b0);
    wait_done();
    for (int p = 0; p < NPIX; p++) begin
      chk($sformatf("flat_r%0d", p), 32'(mem_r[p]), 32'd100);
      chk($sformatf("flat_g%0d", p), 32'(mem_g[p]), 32'd100);
      chk($sformatf("flat_b%0d", p), 32'(mem_b[p]), 32'd100);
    end

    // Corner mirror, RGGB ramp
    cur = ramp_t;
    load_frame(2'b00, 1'b0);
    wait_done();
    chk("corner_g00", 32'(mem_g[0]), 32'd60);
    chk("corner_b00", 32'(mem_b[0]), 32'd90);
    chk("corner_r00", 32'(mem_r[0]), 32'd10);
    chk("green01_r", 32'(mem_r[1]), 32'd20);
    chk("green01_b", 32'(mem_b[1]), 32'd90);
    check_model(2'b00, "ramp");

    // Rounding frame, gap-free reference
    cur = rnd_t;
    load_frame(2'b00, 1'b0);
    wait_done();
    chk("round_r01", 32'(mem_r[1]), RND ? 32'd2 : 32'd1);
    chk("round_b01", 32'(mem_b[1]), 32'd6);
    check_model(2'b00, "rnd");
    snap_r = mem_r; snap_g = mem_g; snap_b = mem_b;

    // Same frame with in_en gaps
    for (int p = 0; p < NPIX; p++) begin
      mem_r[p] = 8'hEE; mem_g[p] = 8'hEE; mem_b[p] = 8'hEE;
    end
    load_frame(2'b00, 1'b1);
    wait_done();
    for (int p = 0; p < NPIX; p++) begin
      chk($sformatf("gap_r%0d", p), 32'(mem_r[p]), 32'(snap_r[p]));
      chk($sformatf("gap_g%0d", p), 32'(mem_g[p]), 32'(snap_g[p]));
      chk($sformatf("gap_b%0d", p), 32'(mem_b[p]), 32'(snap_b[p]));
    end

    // BGGR phase
    cur = ramp_t;
    load_frame(2'b11, 1'b0);
    wait_done();
    chk("bggr_b00", 32'(mem_b[0]), 32'd10);
    chk("bggr_r00", 32'(mem_r[0]), 32'd90);
    chk("bggr_g00", 32'(mem_g[0]), 32'd60);
    check_model(2'b11, "bggr");

    // Reset during FETCH, then a clean frame
    cur = rnd_t;
    load_frame(2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wr", 32'({wr_r, wr_g, wr_b}), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    done_cnt = 0;
    cur = ramp_t;
    load_frame(2'b00, 1'b0);
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", done_cnt, 32'd1);
    check_model(2'b00, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
